// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default data width,
// register-address width and the port-index type used across the slice.
package regfile_sb_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned REG_AW   = $clog2(NREG_DEF);

    typedef logic [REG_AW-1:0] reg_addr_t;
    // Up to four read or write ports per instance.
    typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending producer and keeps a
// registered count of them. Register 0 is never marked busy.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NWR  = 2,
    localparam int unsigned AW  = $clog2(NREG),
    localparam int unsigned CW  = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    output logic [NREG-1:0]   busy,
    output logic [CW-1:0]     busy_cnt
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREG-1:0] clr_mask, set_mask;
    logic [CW-1:0]   n_clr;
    logic            set_en;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        n_clr    = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                clr_mask[wr_addr[j*AW +: AW]] = 1'b1;
            end
        end
        iss_ready = (iss_rd == '0) || !busy_q[iss_rd];
        set_en    = iss_valid && iss_ready && (iss_rd != '0);
        if (set_en) begin
            set_mask[iss_rd] = 1'b1;
        end
        // A set target is never currently busy, so only prior-busy clears count.
        for (int i = 0; i < NREG; i++) begin
            n_clr = n_clr + CW'(busy_q[i] & clr_mask[i]);
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
        cnt_d  = cnt_q + CW'(set_en) - n_clr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with busy scoreboard. Define REGFILE_SB_BYPASS_EN to
// forward same-cycle write data (and cleared busy) to matching read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2,
    localparam int unsigned AW  = $clog2(NREG),
    localparam int unsigned CW  = $clog2(NREG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    output logic [CW-1:0]       busy_cnt
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy;

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    // Ascending port order lets the highest-index writer win on a collision.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                mem_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
            rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])
                    && (rd_addr[k*AW +: AW] != '0)) begin
                    rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    rd_busy[k] = iss_valid && iss_ready && (iss_rd == rd_addr[k*AW +: AW]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized scoreboard bench for regfile_sb with a behavioural reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic              iss_ready;
    logic [CW-1:0]     busy_cnt;

    regfile_sb u_dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] rdata;
        logic [1:0]  rbusy;
        logic        rdy;
        logic [5:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    // Reference state: architectural values and pending-producer flags.
    logic [31:0] m_mem  [NREG];
    bit          m_busy [NREG];
    bit          model_ok = 1'b0;

    task automatic cyc(input bit r, input bit iv, input int ird,
                       input bit we0, input int wa0, input logic [31:0] wd0,
                       input bit we1, input int wa1, input logic [31:0] wd1,
                       input int ra0, input int ra1);
        exp_t e;
        int   ra [2];
        int   wa [2];
        bit   we [2];
        logic [31:0] wd [2];
        bit   acc;
        int   cnt;
        @(negedge clk);
        rst       = r;
        iss_valid = iv;
        iss_rd    = AW'(ird);
        wr_en     = {we1, we0};
        wr_addr   = {AW'(wa1), AW'(wa0)};
        wr_data   = {wd1, wd0};
        rd_addr   = {AW'(ra1), AW'(ra0)};
        ra[0] = ra0; ra[1] = ra1;
        wa[0] = wa0; wa[1] = wa1;
        we[0] = we0; we[1] = we1;
        wd[0] = wd0; wd[1] = wd1;
        acc = iv && ((ird == 0) || !m_busy[ird]);
        if (model_ok) begin
            e.cyc = cyc_no;
            e.rdy = (ird == 0) || !m_busy[ird];
            cnt = 0;
            for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
            e.cnt = 6'(cnt);
            for (int k = 0; k < 2; k++) begin
                logic [31:0] d;
                bit b;
                d = (ra[k] == 0) ? 32'h0 : m_mem[ra[k]];
                b = m_busy[ra[k]];
`ifdef REGFILE_SB_BYPASS_EN
                for (int j = 0; j < 2; j++) begin
                    if (we[j] && wa[j] == ra[k] && ra[k] != 0) begin
                        d = wd[j];
                        b = acc && (ird == ra[k]);
                    end
                end
`endif
                e.rdata[k*32 +: 32] = d;
                e.rbusy[k] = b;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc_no++;
        if (!r) begin
            for (int i = 0; i < NREG; i++) begin
                m_mem[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
            model_ok = 1'b1;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] != 0) begin
                    m_mem[wa[j]]  = wd[j];
                    m_busy[wa[j]] = 1'b0;
                end
            end
            if (acc && ird != 0) m_busy[ird] = 1'b1;
        end
    endtask

    task automatic idle(input int ra0, input int ra1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
    endtask

    // Monitor: outputs are combinational, so one response is due every checked cycle.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_data !== e.rdata) begin
                n_fail++;
                $display("FAIL rd_data cyc=%0d got=%h want=%h", e.cyc, rd_data, e.rdata);
            end
            n_cmp++;
            if (rd_busy !== e.rbusy) begin
                n_fail++;
                $display("FAIL rd_busy cyc=%0d got=%b want=%b", e.cyc, rd_busy, e.rbusy);
            end
            n_cmp++;
            if (iss_ready !== e.rdy) begin
                n_fail++;
                $display("FAIL iss_ready cyc=%0d got=%b want=%b", e.cyc, iss_ready, e.rdy);
            end
            n_cmp++;
            if (busy_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL busy_cnt cyc=%0d got=%0d want=%0d", e.cyc, busy_cnt, e.cnt);
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b0; iss_valid = 1'b0; iss_rd = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset, then read every register on both ports.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NREG; i++) idle(i, NREG - 1 - i);

        // Issue x5, write it back next cycle.
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
        cyc(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        idle(5, 0);

        // WAW stall on x7 until its write lands.
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
        cyc(1, 0, 7, 0, 0, 0, 1, 7, 32'h77, 7, 0);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
        cyc(1, 0, 0, 1, 7, 32'h78, 0, 0, 0, 7, 0);

        // Colliding writes to x3, write to x0.
        cyc(1, 0, 0, 1, 3, 32'h11, 1, 3, 32'h22, 3, 0);
        cyc(1, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 3, 0);
        idle(3, 0);

        // Same-cycle read of x9 during its write.
        cyc(1, 0, 0, 1, 9, 32'h1234, 0, 0, 0, 9, 9);
        idle(9, 9);

        // Issue and write to the same register in one cycle.
        cyc(1, 1, 10, 0, 0, 0, 1, 10, 32'hABCD, 10, 10);
        idle(10, 0);

        // Reset discards pending reservations.
        cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 4, 6);
        cyc(1, 1, 6, 0, 0, 0, 0, 0, 0, 4, 6);
        cyc(0, 1, 8, 1, 4, 32'h44, 0, 0, 0, 4, 6);
        idle(4, 6);

        // Random traffic, addresses mostly in a small window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            bit r;
            int sel;
            sel = ($urandom_range(0, 3) == 0) ? 31 : 7;
            r = ($urandom_range(0, 199) != 0);
            cyc(r, 1'($urandom), $urandom_range(0, sel),
                1'($urandom), $urandom_range(0, sel), $urandom,
                1'($urandom), $urandom_range(0, sel), $urandom,
                $urandom_range(0, sel), $urandom_range(0, sel));
        end
        idle(0, 0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
